// File: rtl/nfc_link_ctrl.sv
// nfc_link_ctrl: half-duplex NFC link arbiter and framer.
// Grants one side per frame (reader=tx, tag=rx) with round-robin arbitration,
// keeps both lines quiet for a guard interval, then sends the latched payload
// LSB first, one bit per BIT_CYCLES-cycle slot, as on-off keying. The far
// side's demodulated envelope is sampled at mid-slot into a capture register.
// Optional feature macro: NFC_PARITY_EN (appends an odd-parity ninth slot and
// reports a parity mismatch on recv_err).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   tx_req/rx_req, *_data    frame requests and payloads (payload sampled at grant)
//   tx_ack/rx_ack            one-cycle pulse at end of the granted frame
//   tx_send/rx_send          OOK line drive
//   tx_recv/rx_recv          demodulated envelopes from the link
//   recv_data/dir/err/valid  capture result of the last frame (valid pulses)
//   busy                     high whenever not idle
module nfc_link_ctrl #(
  parameter int unsigned BIT_CYCLES   = 64,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic       rx_req,
  input  logic [7:0] tx_data,
  input  logic [7:0] rx_data,
  output logic       tx_ack,
  output logic       rx_ack,
  output logic       tx_send,
  output logic       rx_send,
  input  logic       tx_recv,
  input  logic       rx_recv,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  output logic       recv_dir,
  output logic       recv_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef NFC_PARITY_EN
  localparam int unsigned NBITS = 9;
`else
  localparam int unsigned NBITS = 8;
`endif

  localparam int unsigned CNT_MAX = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_MID   = CNT_W'(BIT_CYCLES / 2);
  localparam logic [3:0]       BIT_LAST   = 4'(NBITS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             dir_q, dir_d;     // granted side: 0 = tx, 1 = rx
  logic             last_q, last_d;   // side granted most recently
  logic [8:0]       shift_q, shift_d; // outgoing frame, bit 0 is on the line
  logic [7:0]       cap_q, cap_d;
  logic             par_q, par_d;
  logic             grant_rx_c;
  logic [7:0]       payload_c;
  logic             far_in_c;

  logic       tx_send_d, rx_send_d, tx_ack_d, rx_ack_d, recv_valid_d;
  logic       recv_dir_d, recv_err_d, busy_d;
  logic [7:0] recv_data_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    dir_d        = dir_q;
    last_d       = last_q;
    shift_d      = shift_q;
    cap_d        = cap_q;
    par_d        = par_q;
    tx_ack_d     = 1'b0;
    rx_ack_d     = 1'b0;
    recv_valid_d = 1'b0;
    recv_data_d  = recv_data;
    recv_dir_d   = recv_dir;
    recv_err_d   = recv_err;
    // On a tie, serve the side that was not served last.
    grant_rx_c   = rx_req & (~tx_req | ~last_q);
    payload_c    = grant_rx_c ? rx_data : tx_data;
    far_in_c     = dir_q ? tx_recv : rx_recv;

    case (state_q)
      S_IDLE: begin
        if (tx_req || rx_req) begin
          dir_d   = grant_rx_c;
          last_d  = grant_rx_c;
`ifdef NFC_PARITY_EN
          shift_d = {~(^payload_c), payload_c};
`else
          shift_d = {1'b0, payload_c};
`endif
          cap_d   = 8'h00;
          par_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = 4'd0;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (cnt_q == SLOT_MID) begin
`ifdef NFC_PARITY_EN
          if (bit_q == BIT_LAST) par_d = far_in_c;
          else                   cap_d = {far_in_c, cap_q[7:1]};
`else
          cap_d = {far_in_c, cap_q[7:1]};
`endif
        end
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = 4'd0;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state so they line up with the state.
    tx_send_d = (state_d == S_SEND) & ~dir_d & shift_d[0];
    rx_send_d = (state_d == S_SEND) &  dir_d & shift_d[0];
    busy_d    = (state_d != S_IDLE);
    if (state_q == S_SEND && state_d == S_DONE) begin
      tx_ack_d     = ~dir_q;
      rx_ack_d     = dir_q;
      recv_valid_d = 1'b1;
      recv_data_d  = cap_q;
      recv_dir_d   = dir_q;
`ifdef NFC_PARITY_EN
      recv_err_d   = ~(^{par_q, cap_q});
`else
      recv_err_d   = 1'b0;
`endif
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      dir_q      <= 1'b0;
      last_q     <= 1'b1;
      shift_q    <= 9'd0;
      cap_q      <= 8'h00;
      par_q      <= 1'b0;
      tx_send    <= 1'b0;
      rx_send    <= 1'b0;
      tx_ack     <= 1'b0;
      rx_ack     <= 1'b0;
      recv_valid <= 1'b0;
      recv_data  <= 8'h00;
      recv_dir   <= 1'b0;
      recv_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      dir_q      <= dir_d;
      last_q     <= last_d;
      shift_q    <= shift_d;
      cap_q      <= cap_d;
      par_q      <= par_d;
      tx_send    <= tx_send_d;
      rx_send    <= rx_send_d;
      tx_ack     <= tx_ack_d;
      rx_ack     <= rx_ack_d;
      recv_valid <= recv_valid_d;
      recv_data  <= recv_data_d;
      recv_dir   <= recv_dir_d;
      recv_err   <= recv_err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_nfc_link_ctrl.sv
// Testbench for nfc_link_ctrl: directed and randomized frames checked
// cycle by cycle against a timeline model derived from the frame rules.
`timescale 1ns/1ps
module tb_nfc_link_ctrl;

  localparam int G = 16;
  localparam int B = 64;
`ifdef NFC_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  // Cycles from grant to the following IDLE cycle.
  localparam int L = G + 2 + NB * B;

  logic       clk, rst;
  logic       tx_req, rx_req;
  logic [7:0] tx_data, rx_data;
  logic       tx_ack, rx_ack, tx_send, rx_send, tx_recv, rx_recv;
  logic [7:0] recv_data;
  logic       recv_valid, recv_dir, recv_err, busy;

  logic loop_en, inv_now, far_bit;
  int   checks = 0;
  int   errors = 0;
  bit   last_rx;

  // Link model: loopback of the granted line, optionally corrupted, or a driven bit.
  assign rx_recv = loop_en ? (tx_send ^ inv_now) : far_bit;
  assign tx_recv = loop_en ? (rx_send ^ inv_now) : far_bit;

  nfc_link_ctrl #(.BIT_CYCLES(B), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst),
    .tx_req(tx_req), .rx_req(rx_req),
    .tx_data(tx_data), .rx_data(rx_data),
    .tx_ack(tx_ack), .rx_ack(rx_ack),
    .tx_send(tx_send), .rx_send(rx_send),
    .tx_recv(tx_recv), .rx_recv(rx_recv),
    .recv_data(recv_data), .recv_valid(recv_valid),
    .recv_dir(recv_dir), .recv_err(recv_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [5:0] ctl_vec();
    return {busy, tx_send, rx_send, tx_ack, rx_ack, recv_valid};
  endfunction

  function automatic logic [16:0] all_vec();
    return {busy, tx_send, rx_send, tx_ack, rx_ack, recv_valid, recv_dir, recv_err, recv_data};
  endfunction

  // Round-robin: on a tie the side not served last wins.
  function automatic bit pick_rx(input bit t, input bit r, input bit last);
    if (t && r) return !last;
    return r;
  endfunction

  // Bit i of the transmitted frame; bit 8 is odd parity over the payload.
  function automatic bit frame_bit(input logic [7:0] d, input int i);
    if (i < 8) return d[i];
    return ~(^d);
  endfunction

  // Called in the grant cycle; returns in the following IDLE cycle.
  task automatic run_frame(input bit exp_rx, input logic [7:0] payload,
                           input logic [8:0] far_word, input bit use_loop,
                           input bit inv_par, input bit drop);
    logic [7:0] exp_cap;
    logic [5:0] exp_ctl;
    bit         exp_par, exp_err, bv;
    int         bi;
    loop_en = use_loop;
    inv_now = 1'b0;
    exp_cap = use_loop ? payload : far_word[7:0];
    exp_par = use_loop ? (frame_bit(payload, 8) ^ inv_par) : far_word[8];
    exp_err = (NB == 9) ? ~(^{exp_par, exp_cap}) : 1'b0;
    last_rx = exp_rx;
    for (int off = 1; off <= L; off++) begin
      step();
      if (drop && off == 1) begin
        tx_req = 1'b0; rx_req = 1'b0; tx_data = 8'h00; rx_data = 8'h00;
      end
      exp_ctl = 6'd0;
      if (off < L) exp_ctl[5] = 1'b1;
      if (off >= G + 1 && off <= G + NB * B) begin
        bi = (off - G - 1) / B;
        bv = frame_bit(payload, bi);
        exp_ctl[4] = !exp_rx && bv;
        exp_ctl[3] = exp_rx && bv;
        inv_now = inv_par && (bi == 8);
        // Far bit is only valid at mid-slot; noise elsewhere.
        if ((off - G - 1) % B == B / 2) far_bit = far_word[bi];
        else                            far_bit = 1'($urandom);
      end else begin
        inv_now = 1'b0;
        far_bit = 1'($urandom);
      end
      if (off == L - 1) begin
        exp_ctl[2] = !exp_rx;
        exp_ctl[1] = exp_rx;
        exp_ctl[0] = 1'b1;
      end
      chk("ctl", 32'(ctl_vec()), 32'(exp_ctl));
      if (off >= L - 1) begin
        chk("recv_data", 32'(recv_data), 32'(exp_cap));
        chk("recv_dir", 32'(recv_dir), 32'(exp_rx));
        chk("recv_err", 32'(recv_err), 32'(exp_err));
      end
    end
    inv_now = 1'b0;
  endtask

  initial begin
    logic [7:0] td, rd;
    bit         e, t, r;
    int         sel, gap;
    rst = 1'b0; tx_req = 1'b0; rx_req = 1'b0; tx_data = 8'h00; rx_data = 8'h00;
    loop_en = 1'b0; inv_now = 1'b0; far_bit = 1'b0; last_rx = 1'b1;

    // Reset state.
    repeat (3) step();
    chk("reset_outputs", 32'(all_vec()), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_after_reset", 32'(ctl_vec()), 32'd0);

    // Reader frame 0xA5 with loopback; request dropped and data cleared after grant.
    tx_req = 1'b1; tx_data = 8'hA5;
    run_frame(pick_rx(1'b1, 1'b0, last_rx), 8'hA5, 9'd0, 1'b1, 1'b0, 1'b1);

    // Tag frame 0x3C with loopback.
    rx_req = 1'b1; rx_data = 8'h3C;
    run_frame(pick_rx(1'b0, 1'b1, last_rx), 8'h3C, 9'd0, 1'b1, 1'b0, 1'b1);

    // Both requests held: alternation, random far-side bytes.
    tx_req = 1'b1; rx_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      td = 8'($urandom); rd = 8'($urandom);
      tx_data = td; rx_data = rd;
      e = pick_rx(1'b1, 1'b1, last_rx);
      run_frame(e, e ? rd : td, 9'($urandom), 1'b0, 1'b0, 1'b0);
    end

    // Randomized frames with idle gaps.
    for (int k = 0; k < 6; k++) begin
      gap = $urandom_range(0, 2);
      tx_req = 1'b0; rx_req = 1'b0;
      for (int g = 0; g < gap; g++) begin
        step();
        chk("idle_gap", 32'(ctl_vec()), 32'd0);
      end
      sel = $urandom_range(1, 3);
      t = (sel % 2) == 1;
      r = sel >= 2;
      td = 8'($urandom); rd = 8'($urandom);
      tx_req = t; rx_req = r; tx_data = td; rx_data = rd;
      e = pick_rx(t, r, last_rx);
      run_frame(e, e ? rd : td, 9'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    end

    // Reset in the middle of a reader frame.
    tx_req = 1'b1; rx_req = 1'b0; tx_data = 8'hC3; loop_en = 1'b1;
    repeat (200) step();
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("reset_async", 32'(all_vec()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_hold", 32'(all_vec()), 32'd0);
    end
    rst = 1'b1; last_rx = 1'b1;
    tx_data = 8'h5A;
    run_frame(1'b0, 8'h5A, 9'd0, 1'b1, 1'b0, 1'b1);

    // Payload 0x07 with loopback, then with the ninth slot inverted.
    tx_req = 1'b1; tx_data = 8'h07;
    run_frame(1'b0, 8'h07, 9'd0, 1'b1, 1'b0, 1'b1);
    tx_req = 1'b1; tx_data = 8'h07;
    run_frame(1'b0, 8'h07, 9'd0, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
